// File: rtl/bitstream_decoder.sv
// ---------------------------------------------------------------------------
// bitstream_decoder
//
// Purpose:
//    Converts the 1-bit stochastic stream from the bitstream averager back into
//    a binary count. Counts the ones over a window of 2**LOG2_WIN valid samples
//    and presents that count on o_result. o_done pulses for one cycle whenever
//    o_result is updated.
//
// Parameters:
//    LOG2_WIN     window length is 2**LOG2_WIN valid samples; o_result is
//                 LOG2_WIN+1 bits wide so the all-ones window fits exactly.
//
// Configuration macro:
//    BSD_CONTINUOUS_EN   when defined, the block stays in RUN after a window
//                        completes and immediately starts the next window.
//                        Only i_abort or i_rst return it to IDLE. When
//                        undefined, every window needs its own i_start
//                        pulse issued from IDLE.
//
// Ports:
//    i_clk        in   1            single clock, rising edge
//    i_rst        in   1            synchronous active-high reset
//    i_bit_in     in   1            stochastic sample
//    i_bit_valid  in   1            i_bit_in is counted only when 1
//    i_start      in   1            begin a window (honoured only in IDLE)
//    i_abort      in   1            cancel the current window; result unchanged
//    o_busy       out  1            1 while in RUN (registered)
//    o_done       out  1            one-cycle pulse when o_result is updated
//    o_result     out  LOG2_WIN+1   ones count of the last completed window
//
// The file also contains bitstream_decoder_chk, a simulation-only checker
// that the top level instantiates.
// ---------------------------------------------------------------------------

module bitstream_decoder #(
   parameter int unsigned LOG2_WIN = 8
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_bit_in,
   input  logic                i_bit_valid,
   input  logic                i_start,
   input  logic                i_abort,
   output logic                o_busy,
   output logic                o_done,
   output logic [LOG2_WIN:0]   o_result
);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   // Index of the last sample in a window and the counter increment.
   localparam logic [LOG2_WIN-1:0] SAMPLE_LAST = {LOG2_WIN{1'b1}};
   localparam logic [LOG2_WIN-1:0] SAMPLE_ONE  = LOG2_WIN'(1'b1);

   // State entered after a completed (non-aborted) window.
`ifdef BSD_CONTINUOUS_EN
   localparam state_t ST_AFTER_WIN = ST_RUN;
`else
   localparam state_t ST_AFTER_WIN = ST_IDLE;
`endif

   state_t                r_state;
   state_t                w_state_nxt;
   logic [LOG2_WIN-1:0]   r_sample_cnt;
   logic [LOG2_WIN-1:0]   w_sample_cnt_nxt;
   logic [LOG2_WIN:0]     r_ones_cnt;
   logic [LOG2_WIN:0]     w_ones_cnt_nxt;
   logic [LOG2_WIN:0]     r_result;
   logic [LOG2_WIN:0]     w_result_nxt;
   logic                  r_done;
   logic                  w_done_nxt;
   logic                  r_busy;
   logic                  w_busy_nxt;

   logic [LOG2_WIN:0]     w_bit_ext;
   logic [LOG2_WIN:0]     w_ones_inc;
   logic                  w_win_end;

   // Zero-extended sample and the running count including this sample.
   assign w_bit_ext  = {{LOG2_WIN{1'b0}}, i_bit_in};
   assign w_ones_inc = r_ones_cnt + w_bit_ext;

   // The final valid sample of the window is being presented this cycle.
   assign w_win_end  = (r_state == ST_RUN) && i_bit_valid &&
                       (r_sample_cnt == SAMPLE_LAST);

   // busy is registered from the next state, so it falls with done's rise.
   assign w_busy_nxt = (w_state_nxt == ST_RUN);

   // Next-state, counter and result logic.
   always_comb begin
      w_state_nxt      = r_state;
      w_sample_cnt_nxt = r_sample_cnt;
      w_ones_cnt_nxt   = r_ones_cnt;
      w_result_nxt     = r_result;
      w_done_nxt       = 1'b0;

      case (r_state)
         ST_IDLE: begin
            // abort beats start; the start-cycle sample is never counted.
            if (i_start && !i_abort) begin
               w_state_nxt      = ST_RUN;
               w_sample_cnt_nxt = {LOG2_WIN{1'b0}};
               w_ones_cnt_nxt   = {(LOG2_WIN+1){1'b0}};
            end else begin
               w_state_nxt      = ST_IDLE;
            end
         end

         ST_RUN: begin
            if (i_abort) begin
               // abort beats window end: no done, result left as it was.
               w_state_nxt      = ST_IDLE;
               w_sample_cnt_nxt = {LOG2_WIN{1'b0}};
               w_ones_cnt_nxt   = {(LOG2_WIN+1){1'b0}};
            end else if (w_win_end) begin
               // Final sample is folded straight into the published result.
               w_result_nxt     = w_ones_inc;
               w_done_nxt       = 1'b1;
               w_state_nxt      = ST_AFTER_WIN;
               w_sample_cnt_nxt = {LOG2_WIN{1'b0}};
               w_ones_cnt_nxt   = {(LOG2_WIN+1){1'b0}};
            end else if (i_bit_valid) begin
               w_sample_cnt_nxt = r_sample_cnt + SAMPLE_ONE;
               w_ones_cnt_nxt   = w_ones_inc;
            end else begin
               w_sample_cnt_nxt = r_sample_cnt;
               w_ones_cnt_nxt   = r_ones_cnt;
            end
         end

         default: begin
            w_state_nxt      = ST_IDLE;
            w_sample_cnt_nxt = {LOG2_WIN{1'b0}};
            w_ones_cnt_nxt   = {(LOG2_WIN+1){1'b0}};
         end
      endcase
   end

   // State, counter and output registers.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state      <= ST_IDLE;
         r_sample_cnt <= {LOG2_WIN{1'b0}};
         r_ones_cnt   <= {(LOG2_WIN+1){1'b0}};
         r_result     <= {(LOG2_WIN+1){1'b0}};
         r_done       <= 1'b0;
         r_busy       <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_sample_cnt <= w_sample_cnt_nxt;
         r_ones_cnt   <= w_ones_cnt_nxt;
         r_result     <= w_result_nxt;
         r_done       <= w_done_nxt;
         r_busy       <= w_busy_nxt;
      end
   end

   assign o_busy   = r_busy;
   assign o_done   = r_done;
   assign o_result = r_result;

   bitstream_decoder_chk #(
      .LOG2_WIN (LOG2_WIN)
   ) u_chk (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_busy   (r_busy),
      .i_done   (r_done),
      .i_result (r_result)
   );

endmodule

// ---------------------------------------------------------------------------
// bitstream_decoder_chk
//
// Purpose:
//    Simulation checker for bitstream_decoder output invariants: done is a
//    single-cycle pulse, result never exceeds the window length and, in
//    single-shot builds, busy is already low when done is high.
//
// Ports:
//    i_clk, i_rst  clock and synchronous reset of the checked block
//    i_busy        checked block's busy output
//    i_done        checked block's done output
//    i_result      checked block's result output
// ---------------------------------------------------------------------------

module bitstream_decoder_chk #(
   parameter int unsigned LOG2_WIN = 8
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_busy,
   input  logic                i_done,
   input  logic [LOG2_WIN:0]   i_result
);

   localparam logic [LOG2_WIN:0] RESULT_MAX = {1'b1, {LOG2_WIN{1'b0}}};

   logic r_done_d;

   // Remembers the previous done value and checks the output invariants.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_done_d <= 1'b0;
      end else begin
         r_done_d <= i_done;
         assert (!(r_done_d && i_done))
            else $error("bitstream_decoder_chk: done held for more than one cycle");
         assert (i_result <= RESULT_MAX)
            else $error("bitstream_decoder_chk: result above window length");
`ifndef BSD_CONTINUOUS_EN
         assert (!(i_done && i_busy))
            else $error("bitstream_decoder_chk: busy still high with done");
`endif
      end
   end

endmodule

// File: tb/tb_bitstream_decoder.sv
// ---------------------------------------------------------------------------
// tb_bitstream_decoder
//
// Purpose:
//    Directed, self-checking bench for bitstream_decoder with LOG2_WIN=4
//    (16-sample window). Expected window results are queued when a window is
//    started and compared when the design pulses done; timing and control
//    behaviour is checked directly at each step. Define BSD_CONTINUOUS_EN for
//    both the design and the bench to exercise continuous mode.
// ---------------------------------------------------------------------------

module tb_bitstream_decoder;

   localparam int LW = 4;

   logic          clk       = 1'b0;
   logic          rst       = 1'b1;
   logic          bit_in    = 1'b0;
   logic          bit_valid = 1'b0;
   logic          start     = 1'b0;
   logic          abort     = 1'b0;
   logic          busy;
   logic          done;
   logic [LW:0]   result;

   int            vectors     = 0;
   int            miscompares = 0;
   int            done_seen   = 0;
   int            done_mark   = 0;
   int            sb[$];

   always #5 clk = ~clk;

   bitstream_decoder #(
      .LOG2_WIN (LW)
   ) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_bit_in    (bit_in),
      .i_bit_valid (bit_valid),
      .i_start     (start),
      .i_abort     (abort),
      .o_busy      (busy),
      .o_done      (done),
      .o_result    (result)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One clock: drive inputs, wait for the edge, settle, service the scoreboard.
   task automatic cyc(input logic b, input logic v, input logic s, input logic a);
      bit_in    = b;
      bit_valid = v;
      start     = s;
      abort     = a;
      @(posedge clk);
      #1;
      start = 1'b0;
      abort = 1'b0;
      if (done === 1'b1) begin
         done_seen++;
         if (sb.size() == 0) begin
            chk("spurious_done", {31'd0, done}, 32'd0);
         end else begin
            chk("sb_result", {27'd0, result}, sb.pop_front());
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed running expected finished");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset and idle behaviour.
      rst = 1'b1;
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      rst = 1'b0;
      chk("rst_busy",   {31'd0, busy}, 32'd0);
      chk("rst_done",   {31'd0, done}, 32'd0);
      chk("rst_result", {27'd0, result}, 32'd0);
      for (int i = 0; i < 6; i++) cyc(i[0], 1'b1, 1'b0, 1'b0);
      chk("idle_busy",   {31'd0, busy}, 32'd0);
      chk("idle_result", {27'd0, result}, 32'd0);
      chk("idle_no_done", done_seen, 32'd0);

`ifdef BSD_CONTINUOUS_EN
      // Three back-to-back windows from one start: 16 ones, 16 zeros, 5 ones.
      sb.push_back(16);
      sb.push_back(0);
      sb.push_back(5);
      cyc(1'b1, 1'b1, 1'b1, 1'b0);
      chk("cont_busy_start", {31'd0, busy}, 32'd1);
      for (int blk = 0; blk < 3; blk++) begin
         for (int i = 0; i < 16; i++) begin
            cyc((blk == 0) ? 1'b1 : ((blk == 1) ? 1'b0 : (i < 5)), 1'b1, 1'b0, 1'b0);
            if (i < 15) chk("cont_done_early", {31'd0, done}, 32'd0);
         end
         chk("cont_done_on_time", {31'd0, done}, 32'd1);
         chk("cont_busy_held",    {31'd0, busy}, 32'd1);
      end
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      chk("cont_busy_idle_gap", {31'd0, busy}, 32'd1);
      cyc(1'b1, 1'b1, 1'b0, 1'b1);
      chk("cont_abort_busy",   {31'd0, busy}, 32'd0);
      chk("cont_abort_result", {27'd0, result}, 32'd5);
      chk("cont_done_count",   done_seen, 32'd3);
`else
      // All-ones window; the start-cycle sample must not be counted.
      sb.push_back(16);
      cyc(1'b1, 1'b1, 1'b1, 1'b0);
      chk("t1_busy_start", {31'd0, busy}, 32'd1);
      for (int i = 0; i < 16; i++) begin
         cyc(1'b1, 1'b1, 1'b0, 1'b0);
         if (i < 15) chk("t1_done_early", {31'd0, done}, 32'd0);
      end
      chk("t1_done_on_time", {31'd0, done}, 32'd1);
      chk("t1_result",       {27'd0, result}, 32'd16);
      chk("t1_busy_after",   {31'd0, busy}, 32'd0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      chk("t1_done_width",   {31'd0, done}, 32'd0);
      chk("t1_result_hold",  {27'd0, result}, 32'd16);

      // Alternating 1,0 with three-cycle invalid gaps (gap bits are 1).
      sb.push_back(8);
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 16; i++) begin
         cyc((i % 2) == 0, 1'b1, 1'b0, 1'b0);
         if (i < 15) begin
            chk("t2_done_early", {31'd0, done}, 32'd0);
            for (int g = 0; g < 3; g++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
         end
      end
      chk("t2_done_on_time", {31'd0, done}, 32'd1);
      chk("t2_result",       {27'd0, result}, 32'd8);

      // Abort after 10 samples: no done, result kept.
      done_mark = done_seen;
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 10; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 1'b0, 1'b1);
      chk("t3_abort_busy", {31'd0, busy}, 32'd0);
      for (int i = 0; i < 8; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
      chk("t3_result",     {27'd0, result}, 32'd8);

      // Abort on the 16th sample beats window end.
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 15; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 1'b0, 1'b1);
      chk("t4_done",   {31'd0, done}, 32'd0);
      chk("t4_busy",   {31'd0, busy}, 32'd0);
      chk("t4_result", {27'd0, result}, 32'd8);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      chk("t4_no_done", done_seen, done_mark);

      // Reset mid-window clears result and busy.
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 7; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
      rst = 1'b1;
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      rst = 1'b0;
      chk("t5_result", {27'd0, result}, 32'd0);
      chk("t5_busy",   {31'd0, busy}, 32'd0);
      chk("t5_done",   {31'd0, done}, 32'd0);

      // start re-asserted during RUN (as the 6th valid sample) is ignored.
      sb.push_back(16);
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 10; i++) begin
         cyc(1'b1, 1'b1, 1'b0, 1'b0);
         if (i < 9) chk("t6_done_early", {31'd0, done}, 32'd0);
      end
      chk("t6_done_on_time", {31'd0, done}, 32'd1);
      chk("t6_result",       {27'd0, result}, 32'd16);

      // start together with abort in IDLE: stays IDLE.
      done_mark = done_seen;
      cyc(1'b1, 1'b1, 1'b1, 1'b1);
      chk("t7_busy", {31'd0, busy}, 32'd0);
      for (int i = 0; i < 17; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
      chk("t7_no_done", done_seen, done_mark);
      chk("t7_result",  {27'd0, result}, 32'd16);
`endif

      chk("sb_drained", sb.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
